// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
package dmem_arbiter_pkg;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned N_MST  = 2;
   localparam int unsigned M_CORE = 0;
   localparam int unsigned M_EXT  = 1;

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_LOCK0    = 2'd1,
      ST_LOCK1    = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic              req;
      logic              we;
      logic              lock;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mst_req_t;

   // Masters allowed to win in a given arbitration state
   function automatic logic [1:0] lock_mask(arb_state_e st);
      case (st)
         ST_LOCK0: lock_mask = 2'b01;
         ST_LOCK1: lock_mask = 2'b10;
         default:  lock_mask = 2'b11;
      endcase
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Master-side and memory-side signals of the data-memory arbiter.
interface dmem_arbiter_if;
   import dmem_arbiter_pkg::*;

   logic              m0_req, m0_we, m0_lock, m0_ready, m0_rvalid;
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_wdata, m0_rdata;
   logic              m1_req, m1_we, m1_lock, m1_ready, m1_rvalid;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_wdata, m1_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;
   logic              lock_err;

   modport slave (
      input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
      output m0_ready, m0_rvalid, m0_rdata,
      input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
      output m1_ready, m1_rvalid, m1_rdata,
      output mem_addr, mem_we, mem_wdata,
      input  mem_rdata,
      output lock_err
   );

   modport master (
      output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
      input  m0_ready, m0_rvalid, m0_rdata,
      output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
      input  m1_ready, m1_rvalid, m1_rdata,
      input  mem_addr, mem_we, mem_wdata,
      output mem_rdata,
      input  lock_err
   );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin pick: on a tie the master that did not win last is granted.
module dmem_arbiter_rr_arb2 (
   input  logic [1:0] i_req,
   input  logic       i_last_win,
   input  logic [1:0] i_mask,
   output logic [1:0] o_grant_c
);

   logic [1:0] w_elig;

   always_comb begin
      w_elig    = i_req & i_mask;
      o_grant_c = w_elig;
      if (w_elig == 2'b11) begin
         o_grant_c = i_last_win ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter for the data memory with bus lock, lock timeout
// and registered read responses.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned LOCK_MAX = 16
) (
   input  logic          clk,
   input  logic          reset,
   dmem_arbiter_if.slave bus
);

   localparam int unsigned      CNT_W    = $clog2(LOCK_MAX);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

   arb_state_e        r_state, w_state_nxt;
   logic              r_last_win;
   logic [CNT_W-1:0]  r_lock_cnt, w_lock_cnt_nxt;
   logic              r_lock_err, w_lock_err_nxt;
   logic [1:0]        r_rvalid;
   logic [DATA_W-1:0] r_m0_rdata, r_m1_rdata;

   mst_req_t          w_mreq [N_MST];
   logic [1:0]        w_req, w_grant, w_acc;
   logic              w_owner, w_own_acc, w_own_req, w_own_lock;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [DATA_W-1:0] w_mem_wdata;
   logic              w_mem_we;

   assign w_mreq[M_CORE] = {bus.m0_req, bus.m0_we, bus.m0_lock, bus.m0_addr, bus.m0_wdata};
   assign w_mreq[M_EXT]  = {bus.m1_req, bus.m1_we, bus.m1_lock, bus.m1_addr, bus.m1_wdata};
   assign w_req          = {w_mreq[M_EXT].req, w_mreq[M_CORE].req};

   dmem_arbiter_rr_arb2 u_rr (
      .i_req      (w_req),
      .i_last_win (r_last_win),
      .i_mask     (lock_mask(r_state)),
      .o_grant_c  (w_grant)
   );

   // State logic uses the raw grant; reset only gates what leaves the block
   assign w_acc        = w_grant & w_req;
   assign bus.m0_ready = w_grant[M_CORE] & reset;
   assign bus.m1_ready = w_grant[M_EXT] & reset;

   always_comb begin
      w_mem_addr  = '0;
      w_mem_wdata = '0;
      w_mem_we    = 1'b0;
      if (w_acc[M_CORE]) begin
         w_mem_addr  = w_mreq[M_CORE].addr;
         w_mem_wdata = w_mreq[M_CORE].wdata;
         w_mem_we    = w_mreq[M_CORE].we;
      end else if (w_acc[M_EXT]) begin
         w_mem_addr  = w_mreq[M_EXT].addr;
         w_mem_wdata = w_mreq[M_EXT].wdata;
         w_mem_we    = w_mreq[M_EXT].we;
      end
   end

   assign bus.mem_addr  = w_mem_addr;
   assign bus.mem_wdata = w_mem_wdata;
   assign bus.mem_we    = w_mem_we & reset;

   assign w_owner    = (r_state == ST_LOCK1);
   assign w_own_acc  = w_acc[w_owner];
   assign w_own_req  = w_mreq[w_owner].req;
   assign w_own_lock = w_mreq[w_owner].lock;

   // Next state; the timeout wins over any owner re-lock in the same cycle
   always_comb begin
      w_state_nxt    = r_state;
      w_lock_cnt_nxt = '0;
      w_lock_err_nxt = 1'b0;
      case (r_state)
         ST_UNLOCKED: begin
            if (w_acc[M_CORE] && w_mreq[M_CORE].lock) begin
               w_state_nxt = ST_LOCK0;
            end else if (w_acc[M_EXT] && w_mreq[M_EXT].lock) begin
               w_state_nxt = ST_LOCK1;
            end
         end
         ST_LOCK0, ST_LOCK1: begin
            if (r_lock_cnt == CNT_LAST) begin
               w_state_nxt = ST_UNLOCKED;
            end else if (w_own_acc && !w_own_lock) begin
               w_state_nxt = ST_UNLOCKED;
            end else if (!w_own_req && !w_own_lock) begin
               w_state_nxt = ST_UNLOCKED;
            end
         end
         default: w_state_nxt = ST_UNLOCKED;
      endcase
      if ((w_state_nxt == r_state) && (r_state != ST_UNLOCKED) && !w_own_acc) begin
         w_lock_cnt_nxt = r_lock_cnt + CNT_W'(1);
      end
      // Registered pulse lands in the cycle where the counter sits at its last value
      w_lock_err_nxt = (w_state_nxt != ST_UNLOCKED) && (w_lock_cnt_nxt == CNT_LAST);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_UNLOCKED;
         r_last_win <= 1'b1;
         r_lock_cnt <= '0;
         r_lock_err <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_lock_cnt <= w_lock_cnt_nxt;
         r_lock_err <= w_lock_err_nxt;
         if (|w_acc) begin
            r_last_win <= w_acc[M_EXT];
         end
      end
   end

   // Read responses: one-cycle rvalid, rdata held until that master's next read
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rvalid   <= 2'b00;
         r_m0_rdata <= '0;
         r_m1_rdata <= '0;
      end else begin
         r_rvalid[M_CORE] <= w_acc[M_CORE] & ~w_mreq[M_CORE].we;
         r_rvalid[M_EXT]  <= w_acc[M_EXT] & ~w_mreq[M_EXT].we;
         if (w_acc[M_CORE] && !w_mreq[M_CORE].we) begin
            r_m0_rdata <= bus.mem_rdata;
         end
         if (w_acc[M_EXT] && !w_mreq[M_EXT].we) begin
            r_m1_rdata <= bus.mem_rdata;
         end
      end
   end

   assign bus.m0_rvalid = r_rvalid[M_CORE];
   assign bus.m1_rvalid = r_rvalid[M_EXT];
   assign bus.m0_rdata  = r_m0_rdata;
   assign bus.m1_rdata  = r_m1_rdata;
   assign bus.lock_err  = r_lock_err;

endmodule
